rotary_decoder: RTL and testbench
=================================

ROTARY_DECODER -- requirements
Module: rotary_decoder

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 1000, the consecutive stable cycles (>=1) needed before a filtered input changes.
REQ-002 The module SHALL have parameter BASE_SPEED, default 4, the 5-bit speed reported when not accelerating.
REQ-003 The module SHALL have parameter ACCEL_WINDOW, default 2500000, the maximum inter-detent gap in cycles that counts as fast turning.
REQ-004 clock  input  1  single system clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 rot_a  input  1  raw encoder channel A, asynchronous to clock.
REQ-007 rot_b  input  1  raw encoder channel B, asynchronous to clock.
REQ-008 rotary_event  output  1  one-cycle pulse per completed detent.
REQ-009 rotary_right  output  1  direction of last detent (1 = clockwise), held between events.
REQ-010 speed  output  5  per-detent step size for the paddle controller.

Function
REQ-011 Each of rot_a, rot_b SHALL pass through a 2-flop synchronizer.
REQ-012 Each synchronized bit SHALL update its filtered value only after differing from it for DEBOUNCE_CYCLES consecutive cycles; any return to agreement SHALL clear that bit's counter.
REQ-013 A raw level change held stable SHALL appear on the filtered bit exactly 2 + DEBOUNCE_CYCLES clocks after the edge is sampled.
REQ-014 The decoder FSM SHALL use states REST, CW1, CW2, CW3, CCW1, CCW2, CCW3, evaluated on filtered AB each cycle.
REQ-015 REST: AB=01 -> CW1; AB=10 -> CCW1; otherwise hold.
REQ-016 CW1: 00 -> CW2; 11 -> REST, no event.  CW2: 10 -> CW3; 01 -> CW1.  CW3: 00 -> CW2; 11 -> REST with event, direction right.
REQ-017 CCW1: 00 -> CCW2; 11 -> REST, no event.  CCW2: 01 -> CCW3; 10 -> CCW1.  CCW3: 00 -> CCW2; 11 -> REST with event, direction left.
REQ-018 In any non-REST state, filtered AB=11 not covered above (double-bit jump) SHALL return to REST with no event; any other uncovered code SHALL hold state.
REQ-019 rotary_event SHALL be registered, high for exactly one cycle, in the cycle after the filtered AB that completes CW3 or CCW3 -> REST.
REQ-020 rotary_right SHALL update in the same cycle rotary_event rises (1 for CW, 0 for CCW) and otherwise hold.
REQ-021 Two events SHALL never be adjacent; minimum spacing follows from debounce.

Reset
REQ-022 Assertion of reset_n low SHALL immediately force: synchronizer flops and filtered bits to 1, debounce counters 0, FSM REST, rotary_event 0, rotary_right 0, speed BASE_SPEED, gap counter 0.
REQ-023 Reset asserted mid-sequence SHALL discard the partial detent; no event after release until a full new sequence.

Configuration
REQ-024 With ROTARY_ACCEL_EN defined, a gap counter SHALL count cycles since the last event, saturating at ACCEL_WINDOW, and clear on each event.
REQ-025 With ROTARY_ACCEL_EN, on each event speed SHALL become min(speed+1, 31) if gap < ACCEL_WINDOW, else BASE_SPEED, updating in the same cycle as rotary_event.
REQ-026 Without ROTARY_ACCEL_EN, speed SHALL be constant BASE_SPEED and no gap counter SHALL exist.

Verification (DEBOUNCE_CYCLES=4, ACCEL_WINDOW=100)
REQ-027 AB 11->01->00->10->11, each held 20 cycles -> one rotary_event pulse, rotary_right=1, pulse 7 clocks after final edge.
REQ-028 AB 11->10->00->01->11 -> one pulse, rotary_right=0; prior direction overwritten.
REQ-029 rot_a glitch of 3 cycles during REST -> no filtered change, no event; CW1 then back to 11 -> no event.
REQ-030 Reset_n pulsed low while in CW3, then AB driven to 11 -> no event, speed=4, rotary_right=0.
REQ-031 ROTARY_ACCEL_EN: three CW detents 50 cycles apart -> speed 4, 5, 6; next detent after 200 idle cycles -> speed 4; 40 fast detents -> speed saturates at 31.

Source files
------------

// File: rtl/rotary_decoder.sv
// Quadrature rotary encoder decoder: 2-flop sync, per-bit debounce, detent FSM.
// Define ROTARY_ACCEL_EN to enable speed acceleration on fast turning.
module rotary_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter logic [4:0]  BASE_SPEED      = 5'd4,
    parameter int unsigned ACCEL_WINDOW    = 2500000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rot_a,
    input  logic       rot_b,
    output logic       rotary_event,
    output logic       rotary_right,
    output logic [4:0] speed
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || ACCEL_WINDOW < 1) begin : g_param_check
        $error("rotary_decoder: DEBOUNCE_CYCLES and ACCEL_WINDOW must be >= 1");
    end

    typedef enum logic [2:0] {
        StRest,
        StCw1,
        StCw2,
        StCw3,
        StCcw1,
        StCcw2,
        StCcw3
    } state_e;

    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       filt_q;
    logic [CNT_W-1:0] cnt_q [2];
    state_e           state_q;
    logic             detent_done;

    // Bit 1 is channel A, bit 0 is channel B throughout.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            filt_q  <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= {rot_a, rot_b};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        filt_q[i] <= sync2_q[i];
                        cnt_q[i]  <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign detent_done = (filt_q == 2'b11) && (state_q == StCw3 || state_q == StCcw3);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StRest;
            rotary_event <= 1'b0;
            rotary_right <= 1'b0;
        end else begin
            rotary_event <= 1'b0;
            case (state_q)
                StRest: begin
                    if (filt_q == 2'b01) state_q <= StCw1;
                    else if (filt_q == 2'b10) state_q <= StCcw1;
                end
                StCw1: begin
                    if (filt_q == 2'b00) state_q <= StCw2;
                    else if (filt_q == 2'b11) state_q <= StRest;
                end
                StCw2: begin
                    if (filt_q == 2'b10) state_q <= StCw3;
                    else if (filt_q == 2'b01) state_q <= StCw1;
                    else if (filt_q == 2'b11) state_q <= StRest;
                end
                StCw3: begin
                    if (filt_q == 2'b00) begin
                        state_q <= StCw2;
                    end else if (filt_q == 2'b11) begin
                        state_q      <= StRest;
                        rotary_event <= 1'b1;
                        rotary_right <= 1'b1;
                    end
                end
                StCcw1: begin
                    if (filt_q == 2'b00) state_q <= StCcw2;
                    else if (filt_q == 2'b11) state_q <= StRest;
                end
                StCcw2: begin
                    if (filt_q == 2'b01) state_q <= StCcw3;
                    else if (filt_q == 2'b10) state_q <= StCcw1;
                    else if (filt_q == 2'b11) state_q <= StRest;
                end
                StCcw3: begin
                    if (filt_q == 2'b00) begin
                        state_q <= StCcw2;
                    end else if (filt_q == 2'b11) begin
                        state_q      <= StRest;
                        rotary_event <= 1'b1;
                        rotary_right <= 1'b0;
                    end
                end
                default: state_q <= StRest;
            endcase
        end
    end

`ifdef ROTARY_ACCEL_EN
    localparam int unsigned GAP_W = $clog2(ACCEL_WINDOW + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(ACCEL_WINDOW);

    logic [GAP_W-1:0] gap_q;
    logic [4:0]       speed_q;

    // gap_q saturates so a long idle period always reads as slow turning.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gap_q   <= '0;
            speed_q <= BASE_SPEED;
        end else if (detent_done) begin
            gap_q <= '0;
            if (gap_q < GAP_MAX) begin
                speed_q <= (speed_q == 5'd31) ? 5'd31 : speed_q + 5'd1;
            end else begin
                speed_q <= BASE_SPEED;
            end
        end else if (gap_q != GAP_MAX) begin
            gap_q <= gap_q + GAP_W'(1);
        end
    end

    assign speed = speed_q;
`else
    assign speed = BASE_SPEED;
`endif

endmodule

// File: tb/tb_rotary_decoder.sv
// Randomized + directed bench for rotary_decoder against a detent-sequence model.
// Speed expectations follow ROTARY_ACCEL_EN when it is defined for the build.
module tb_rotary_decoder;

    localparam int         D    = 4;
    localparam int         W    = 100;
    localparam logic [4:0] BASE = 5'd4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rot_a;
    logic       rot_b;
    logic       rotary_event;
    logic       rotary_right;
    logic [4:0] speed;

    always #5 clock = ~clock;

    rotary_decoder #(
        .DEBOUNCE_CYCLES(D),
        .BASE_SPEED     (BASE),
        .ACCEL_WINDOW   (W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rot_a       (rot_a),
        .rot_b       (rot_b),
        .rotary_event(rotary_event),
        .rotary_right(rotary_right),
        .speed       (speed)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: position k along the detent's code sequence, direction dir.
    int         k         = 0;
    int         dir       = 1;
    logic [1:0] cur       = 2'b11;
    logic       exp_right = 1'b0;
    logic [4:0] exp_speed = BASE;
    int         last_ev   = 0;
    int         ev_q[$];
    bit         dir_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Gray code at index idx of a full detent in direction d (index 0 and 4 are rest).
    function automatic logic [1:0] seq_code(input int d, input int idx);
        case (idx)
            1:       return (d > 0) ? 2'b01 : 2'b10;
            2:       return 2'b00;
            3:       return (d > 0) ? 2'b10 : 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    // New stable code c is first sampled on posedge cyc+1; a completed detent
    // shows up as a pulse D+2 edges after that.
    task automatic model_apply(input logic [1:0] c);
        if (k == 0) begin
            if (c == 2'b01) begin
                dir = 1;
                k   = 1;
            end else if (c == 2'b10) begin
                dir = -1;
                k   = 1;
            end
        end else if (c == seq_code(dir, k + 1)) begin
            if (k == 3) begin
                ev_q.push_back(cyc + 1 + 2 + D);
                dir_q.push_back(dir > 0);
                k = 0;
            end else begin
                k = k + 1;
            end
        end else if (c == seq_code(dir, k - 1)) begin
            k = k - 1;
        end else if (c == 2'b11) begin
            k = 0;
        end
        cur = c;
    endtask

    task automatic tick();
        logic ev_exp;
        int   gap;
        @(posedge clock);
        cyc++;
        @(negedge clock);
        ev_exp = 1'b0;
        if (ev_q.size() > 0 && ev_q[0] == cyc) begin
            ev_exp = 1'b1;
            void'(ev_q.pop_front());
            exp_right = dir_q.pop_front();
`ifdef ROTARY_ACCEL_EN
            gap = cyc - 1 - last_ev;
            if (gap > W) gap = W;
            if (gap < W) exp_speed = (exp_speed == 5'd31) ? 5'd31 : exp_speed + 5'd1;
            else exp_speed = BASE;
            last_ev = cyc;
`else
            gap = 0;
`endif
        end
        check("event", rotary_event, ev_exp);
        check("right", rotary_right, exp_right);
        check("speed", speed, exp_speed);
    endtask

    task automatic drive(input logic [1:0] c, input int hold);
        rot_a = c[1];
        rot_b = c[0];
        model_apply(c);
        repeat (hold) tick();
    endtask

    task automatic glitch(input int sel, input int len, input int hold);
        logic [1:0] g;
        g = cur ^ (sel[0] ? 2'b10 : 2'b01);
        rot_a = g[1];
        rot_b = g[0];
        repeat (len) tick();
        rot_a = cur[1];
        rot_b = cur[0];
        repeat (hold) tick();
    endtask

    task automatic detent(input int d, input int hold);
        for (int i = 1; i <= 4; i++) drive(seq_code(d, i), hold);
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        rot_a   = 1'b1;
        rot_b   = 1'b1;
        #1;
        check("rst_event", rotary_event, 1'b0);
        check("rst_right", rotary_right, 1'b0);
        check("rst_speed", speed, BASE);
        k         = 0;
        cur       = 2'b11;
        exp_right = 1'b0;
        exp_speed = BASE;
        ev_q.delete();
        dir_q.delete();
        repeat (3) tick();
        reset_n = 1'b1;
        last_ev = cyc;
    endtask

    initial begin
        logic [1:0] nb;
        int         r;
        int         hold;

        rot_a = 1'b1;
        rot_b = 1'b1;
        @(negedge clock);
        reset_pulse();

        // Clockwise detent, then counter-clockwise overwriting direction.
        detent(1, 20);
        repeat (10) tick();
        check("cw_dir", rotary_right, 1'b1);
        detent(-1, 20);
        repeat (10) tick();
        check("ccw_dir", rotary_right, 1'b0);

        // Short glitch at rest, then an abandoned CW1.
        glitch(1, 3, 20);
        drive(2'b01, 20);
        drive(2'b11, 20);

        // Reset while sitting in CW3.
        detent(1, 20);
        drive(2'b01, 20);
        drive(2'b00, 20);
        drive(2'b10, 20);
        reset_pulse();
        drive(2'b11, 20);
        check("post_rst_right", rotary_right, 1'b0);
        check("post_rst_speed", speed, BASE);

        // Acceleration pattern: slow start, fast triple, idle, fast burst.
        repeat (200) tick();
        for (int i = 0; i < 3; i++) detent(1, 12);
        repeat (200) tick();
        detent(1, 12);
        for (int i = 0; i < 40; i++) detent(1, D + 2);
        repeat (10) tick();
`ifdef ROTARY_ACCEL_EN
        check("speed_sat", speed, 5'd31);
`endif

        // Random walk over gray neighbours, double jumps, glitches and idles.
        for (int i = 0; i < 300; i++) begin
            r    = $urandom_range(0, 9);
            hold = $urandom_range(D + 2, D + 12);
            if (r <= 6) begin
                nb = cur ^ ($urandom_range(0, 1) != 0 ? 2'b10 : 2'b01);
                drive(nb, hold);
            end else if (r == 7) begin
                drive(cur ^ 2'b11, hold);
            end else if (r == 8) begin
                glitch($urandom_range(0, 1), $urandom_range(1, D - 1), hold);
            end else begin
                nb = cur ^ ($urandom_range(0, 1) != 0 ? 2'b10 : 2'b01);
                drive(nb, $urandom_range(150, 250));
            end
        end
        drive(2'b11, 30);
        check("pending_events", ev_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
